fibonacci_stream: RTL and testbench
===================================

// Module: fibonacci_stream
// PURPOSE
//  Parametrised Fibonacci-recurrence generator with a streaming output. The
//  caller supplies seeds and a term count; the block emits f(0)..f(N-1) one
//  term per valid/ready transfer, with f(n)=f(n-1)+f(n-2) mod 2^WIDTH.
//  Overflow handling is selectable: wrap, or stop. Feeds display/checker logic.
// PARAMETERS
//  WIDTH     6  term width in bits (>=2)
//  CNT_W     6  width of num_terms/out_index; max run = 2^CNT_W-1 terms
//  OVF_MODE  0  0: wrap and flag; 1: stop before emitting first overflowed term
// PORTS
//  clock      in   1      rising-edge clock, the only clock
//  reset      in   1      asynchronous, active-low (0 = reset asserted)
//  start      in   1      run request, sampled in IDLE only
//  f0         in   WIDTH  seed term 0, captured on accepted start
//  f1         in   WIDTH  seed term 1, captured on accepted start
//  num_terms  in   CNT_W  terms to emit, captured on accepted start
//  out_ready  in   1      consumer accepts out_data this cycle
//  out_valid  out  1      out_data/out_index hold a term
//  out_data   out  WIDTH  current term
//  out_index  out  CNT_W  index n of current term
//  busy       out  1      1 while in RUN
//  done       out  1      one-cycle pulse at end of run
//  overflow   out  1      sticky: an emitted/suppressed term exceeded 2^WIDTH-1
// BEHAVIOUR
//  - Reset (reset=0): immediately state=IDLE; out_valid, out_data, out_index,
//    busy, done, overflow all 0; internal a, b, carry, count cleared.
//  - States: IDLE, RUN. Transfer = out_valid & out_ready at a clock edge.
//  - IDLE & start & num_terms!=0: capture seeds/count, clear overflow; next
//    cycle RUN, out_valid=1, out_data=f0, out_index=0 (latency 1 cycle).
//    Internal a=f0, b=f1, b_carry=0.
//  - IDLE & start & num_terms==0: done=1 for one cycle, stay IDLE, out_valid
//    never rises; overflow cleared.
//  - RUN, no transfer: out_data/out_index held stable, out_valid stays 1.
//  - RUN, transfer, out_index==num_terms-1: next cycle IDLE, out_valid=0,
//    done=1 for one cycle. out_data/out_index keep last values.
//  - RUN, transfer, more terms: next term is b with carry b_carry:
//    OVF_MODE=0 or b_carry=0: out_data<=b, out_index+1, a<=b,
//      {b_carry,b}<=a+b (WIDTH+1-bit sum of truncated operands);
//      overflow<=1 if b_carry=1.
//    OVF_MODE=1 and b_carry=1: term suppressed; next cycle IDLE,
//      out_valid=0, done=1, overflow=1.
//  - Once set, overflow stays 1 until the next accepted start or reset.
//  - start while RUN: ignored. start in the done cycle: accepted (state IDLE).
//  - busy = (state==RUN). done and out_valid are never high together.
//  - Reset asserted mid-run aborts the run; no done pulse is produced.
// TESTING
//  1 WIDTH=6, f0=f1=1, num_terms=8, out_ready=1 -> out_data 1,1,2,3,5,8,13,21
//    on 8 consecutive cycles, index 0..7; done pulse next cycle; overflow=0.
//  2 As 1, out_ready=0 for 3 cycles while index=3 -> out_data=3 held stable,
//    sequence resumes 5,8,... with no term skipped or repeated.
//  3 OVF_MODE=0, f0=f1=1, num_terms=12 -> ...,34,55,25(idx10),16(idx11);
//    overflow rises with idx10 presentation; done after idx11.
//  4 OVF_MODE=1, same stimulus -> last term 55 at idx9; then out_valid=0,
//    done=1 one cycle, overflow=1, busy=0; restart clears overflow.
//  5 Drive reset=0 asynchronously between clock edges at idx4 -> all outputs 0
//    without waiting for a clock edge; after release, idle until start.
//  6 start with num_terms=0 -> single done pulse, no out_valid; start pulsed
//    during RUN -> ignored, sequence unchanged.

Source files
------------

// File: rtl/fibonacci_stream.sv
// rtl/fibonacci_stream.sv - Fibonacci-recurrence term generator with valid/ready output stream
//
// Purpose:
//    Emits f(0)..f(N-1) of f(n) = f(n-1) + f(n-2) mod 2^WIDTH, one term per
//    out_valid & out_ready transfer. Overflow either wraps (and sets a sticky
//    flag) or stops the run before the first overflowed term (OVF_MODE=1).
//
// Ports:
//    clock      in   1      rising-edge clock
//    reset      in   1      asynchronous, active-low
//    start      in   1      run request, sampled in IDLE only
//    f0, f1     in   WIDTH  seed terms, captured on accepted start
//    num_terms  in   CNT_W  terms to emit, captured on accepted start
//    out_ready  in   1      consumer accepts the current term
//    out_valid  out  1      out_data/out_index hold a term
//    out_data   out  WIDTH  current term
//    out_index  out  CNT_W  index of current term
//    busy       out  1      run in progress
//    done       out  1      one-cycle pulse at end of run
//    overflow   out  1      sticky overflow flag, cleared by accepted start

module fibonacci_stream #(
   parameter int WIDTH    = 6,
   parameter int CNT_W    = 6,
   parameter int OVF_MODE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] f0,
   input  logic [WIDTH-1:0] f1,
   input  logic [CNT_W-1:0] num_terms,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_index,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             b_carry_q, b_carry_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] index_q, index_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   sum;

   // a holds the presented term, b the next one; the sum is taken on the
   // truncated operands so the carry marks the term after b as overflowed.
   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      b_carry_d = b_carry_q;
      count_d   = count_q;
      data_d    = data_q;
      index_d   = index_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;

      if (state_q == IDLE) begin
         if (start) begin
            ovf_d = 1'b0;
            if (num_terms == '0) begin
               done_d = 1'b1;
            end else begin
               state_d   = RUN;
               count_d   = num_terms;
               a_d       = f0;
               b_d       = f1;
               b_carry_d = 1'b0;
               data_d    = f0;
               index_d   = '0;
            end
         end
      end else if (out_ready) begin
         if (index_q == count_q - CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else if ((OVF_MODE != 0) && b_carry_q) begin
            // Stop mode: the next term would be an overflowed value, so it is
            // never presented.
            state_d = IDLE;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
         end else begin
            data_d               = b_q;
            index_d              = index_q + CNT_ONE;
            a_d                  = b_q;
            {b_carry_d, b_d}     = sum;
            if (b_carry_q) begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         b_carry_q <= 1'b0;
         count_q   <= '0;
         data_q    <= '0;
         index_q   <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         b_carry_q <= b_carry_d;
         count_q   <= count_d;
         data_q    <= data_d;
         index_q   <= index_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign out_valid = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign out_data  = data_q;
   assign out_index = index_q;
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fibonacci_stream.sv
// tb/tb_fibonacci_stream.sv - directed bench for fibonacci_stream in wrap and stop overflow modes

module tb_fibonacci_stream;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [5:0] f0 = '0;
   logic [5:0] f1 = '0;
   logic [5:0] num_terms = '0;
   logic       out_ready = 1'b1;

   logic       v0, b0, dn0, o0;
   logic [5:0] d0, i0;
   logic       v1, b1, dn1, o1;
   logic [5:0] d1, i1;

   int total = 0;
   int bad   = 0;
   int exp_seq [12] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 25, 16};

   always #5 clock = ~clock;

   fibonacci_stream #(.WIDTH(6), .CNT_W(6), .OVF_MODE(0)) dut_wrap (
      .clock(clock), .reset(reset), .start(start), .f0(f0), .f1(f1),
      .num_terms(num_terms), .out_ready(out_ready), .out_valid(v0),
      .out_data(d0), .out_index(i0), .busy(b0), .done(dn0), .overflow(o0));

   fibonacci_stream #(.WIDTH(6), .CNT_W(6), .OVF_MODE(1)) dut_stop (
      .clock(clock), .reset(reset), .start(start), .f0(f0), .f1(f1),
      .num_terms(num_terms), .out_ready(out_ready), .out_valid(v1),
      .out_data(d1), .out_index(i1), .busy(b1), .done(dn1), .overflow(o1));

   // Caller is at a negedge; returns at the negedge where term 0 is presented.
   task automatic start_run(input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] n);
      start = 1'b1; f0 = s0; f1 = s1; num_terms = n;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic drain_idle();
      int budget = 60;
      while ((b0 || b1) && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      total++;
      if (b0 || b1) begin
         bad++;
         $display("FAIL drain_timeout got busy=%0d/%0d want=0/0", b0, b1);
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #1;
      total++;
      if ({v0, b0, dn0, o0, d0, i0} !== 16'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%0h want=0", {v0, b0, dn0, o0, d0, i0});
      end
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      total++;
      if (v0 !== 1'b0 || b0 !== 1'b0 || v1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle got valid=%0d busy=%0d want=0", v0, b0);
      end
   endtask

   task automatic test_basic();
      start_run(6'd1, 6'd1, 6'd8);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (v0 !== 1'b1 || d0 !== 6'(exp_seq[i]) || i0 !== 6'(i) || o0 !== 1'b0 || b0 !== 1'b1) begin
            bad++;
            $display("FAIL basic_term%0d got v=%0d d=%0d i=%0d o=%0d want v=1 d=%0d i=%0d o=0",
                     i, v0, d0, i0, o0, exp_seq[i], i);
         end
         @(negedge clock);
      end
      total++;
      if (dn0 !== 1'b1 || v0 !== 1'b0 || b0 !== 1'b0 || o0 !== 1'b0 || d0 !== 6'd21 || i0 !== 6'd7) begin
         bad++;
         $display("FAIL basic_done got dn=%0d v=%0d b=%0d o=%0d d=%0d i=%0d want 1 0 0 0 21 7",
                  dn0, v0, b0, o0, d0, i0);
      end
      @(negedge clock);
      total++;
      if (dn0 !== 1'b0) begin
         bad++;
         $display("FAIL basic_done_pulse got=%0d want=0", dn0);
      end
   endtask

   task automatic test_backpressure();
      start_run(6'd1, 6'd1, 6'd8);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (v0 !== 1'b1 || d0 !== 6'(exp_seq[i]) || i0 !== 6'(i)) begin
            bad++;
            $display("FAIL bp_term%0d got v=%0d d=%0d i=%0d want v=1 d=%0d i=%0d",
                     i, v0, d0, i0, exp_seq[i], i);
         end
         if (i == 3) begin
            out_ready = 1'b0;
            for (int h = 0; h < 3; h++) begin
               @(negedge clock);
               total++;
               if (v0 !== 1'b1 || d0 !== 6'd3 || i0 !== 6'd3 || dn0 !== 1'b0) begin
                  bad++;
                  $display("FAIL bp_hold%0d got v=%0d d=%0d i=%0d dn=%0d want v=1 d=3 i=3 dn=0",
                           h, v0, d0, i0, dn0);
               end
            end
            out_ready = 1'b1;
         end
         @(negedge clock);
      end
      total++;
      if (dn0 !== 1'b1 || v0 !== 1'b0) begin
         bad++;
         $display("FAIL bp_done got dn=%0d v=%0d want dn=1 v=0", dn0, v0);
      end
      @(negedge clock);
   endtask

   task automatic test_wrap();
      start_run(6'd1, 6'd1, 6'd12);
      for (int i = 0; i < 12; i++) begin
         total++;
         if (v0 !== 1'b1 || d0 !== 6'(exp_seq[i]) || i0 !== 6'(i) || o0 !== (i >= 10)) begin
            bad++;
            $display("FAIL wrap_term%0d got v=%0d d=%0d i=%0d o=%0d want v=1 d=%0d i=%0d o=%0d",
                     i, v0, d0, i0, o0, exp_seq[i], i, (i >= 10));
         end
         @(negedge clock);
      end
      total++;
      if (dn0 !== 1'b1 || v0 !== 1'b0 || o0 !== 1'b1 || d0 !== 6'd16) begin
         bad++;
         $display("FAIL wrap_done got dn=%0d v=%0d o=%0d d=%0d want 1 0 1 16", dn0, v0, o0, d0);
      end
      drain_idle();
   endtask

   task automatic test_stop();
      start_run(6'd1, 6'd1, 6'd12);
      for (int i = 0; i < 10; i++) begin
         total++;
         if (v1 !== 1'b1 || d1 !== 6'(exp_seq[i]) || i1 !== 6'(i) || o1 !== 1'b0) begin
            bad++;
            $display("FAIL stop_term%0d got v=%0d d=%0d i=%0d o=%0d want v=1 d=%0d i=%0d o=0",
                     i, v1, d1, i1, o1, exp_seq[i], i);
         end
         @(negedge clock);
      end
      total++;
      if (v1 !== 1'b0 || dn1 !== 1'b1 || o1 !== 1'b1 || b1 !== 1'b0 || d1 !== 6'd55 || i1 !== 6'd9) begin
         bad++;
         $display("FAIL stop_end got v=%0d dn=%0d o=%0d b=%0d d=%0d i=%0d want 0 1 1 0 55 9",
                  v1, dn1, o1, b1, d1, i1);
      end
      @(negedge clock);
      total++;
      if (dn1 !== 1'b0 || v1 !== 1'b0 || o1 !== 1'b1) begin
         bad++;
         $display("FAIL stop_after got dn=%0d v=%0d o=%0d want 0 0 1", dn1, v1, o1);
      end
      drain_idle();
      start_run(6'd1, 6'd1, 6'd2);
      total++;
      if (o1 !== 1'b0 || v1 !== 1'b1 || d1 !== 6'd1) begin
         bad++;
         $display("FAIL stop_restart got o=%0d v=%0d d=%0d want o=0 v=1 d=1", o1, v1, d1);
      end
      drain_idle();
   endtask

   task automatic test_async_reset();
      start_run(6'd1, 6'd1, 6'd8);
      repeat (4) @(negedge clock);
      total++;
      if (i0 !== 6'd4 || d0 !== 6'd5) begin
         bad++;
         $display("FAIL areset_pre got d=%0d i=%0d want d=5 i=4", d0, i0);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({v0, b0, dn0, o0, d0, i0} !== 16'd0 || v1 !== 1'b0) begin
         bad++;
         $display("FAIL areset_clear got=%0h want=0", {v0, b0, dn0, o0, d0, i0});
      end
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         total++;
         if (v0 !== 1'b0 || b0 !== 1'b0 || dn0 !== 1'b0) begin
            bad++;
            $display("FAIL areset_idle%0d got v=%0d b=%0d dn=%0d want 0 0 0", k, v0, b0, dn0);
         end
      end
   endtask

   task automatic test_zero_terms();
      start_run(6'd3, 6'd4, 6'd0);
      total++;
      if (dn0 !== 1'b1 || v0 !== 1'b0 || b0 !== 1'b0) begin
         bad++;
         $display("FAIL zero_done got dn=%0d v=%0d b=%0d want 1 0 0", dn0, v0, b0);
      end
      @(negedge clock);
      total++;
      if (dn0 !== 1'b0 || v0 !== 1'b0) begin
         bad++;
         $display("FAIL zero_after got dn=%0d v=%0d want 0 0", dn0, v0);
      end
   endtask

   task automatic test_start_during_run();
      start_run(6'd1, 6'd1, 6'd5);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (v0 !== 1'b1 || d0 !== 6'(exp_seq[i]) || i0 !== 6'(i)) begin
            bad++;
            $display("FAIL ignore_term%0d got v=%0d d=%0d i=%0d want v=1 d=%0d i=%0d",
                     i, v0, d0, i0, exp_seq[i], i);
         end
         if (i == 1) begin
            start = 1'b1; f0 = 6'd7; f1 = 6'd7; num_terms = 6'd3;
         end
         if (i == 3) start = 1'b0;
         @(negedge clock);
      end
      total++;
      if (dn0 !== 1'b1 || v0 !== 1'b0) begin
         bad++;
         $display("FAIL ignore_done got dn=%0d v=%0d want 1 0", dn0, v0);
      end
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      start_run(6'd2, 6'd3, 6'd2);
      @(negedge clock);
      total++;
      if (d0 !== 6'd3 || i0 !== 6'd1 || v0 !== 1'b1) begin
         bad++;
         $display("FAIL b2b_term1 got d=%0d i=%0d v=%0d want 3 1 1", d0, i0, v0);
      end
      @(negedge clock);
      total++;
      if (dn0 !== 1'b1 || v0 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_done got dn=%0d v=%0d want 1 0", dn0, v0);
      end
      start_run(6'd4, 6'd4, 6'd1);
      total++;
      if (v0 !== 1'b1 || d0 !== 6'd4 || i0 !== 6'd0 || dn0 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_restart got v=%0d d=%0d i=%0d dn=%0d want 1 4 0 0", v0, d0, i0, dn0);
      end
      @(negedge clock);
      total++;
      if (dn0 !== 1'b1 || v0 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_done2 got dn=%0d v=%0d want 1 0", dn0, v0);
      end
      drain_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_stop();
      test_async_reset();
      test_zero_terms();
      test_start_during_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
